seg7_disp_arbiter: RTL
======================

# seg7_disp_arbiter

Shares the single 4-digit seven-segment display between up to NREQ requesters, each offering a 16-bit value: free-running counter, key codes, ADC readings, debug words. Sits between the value sources and the seg4x7 scanner and drives the scanner's 16-bit `in` bus. When no source requests, a default value is shown. Grants are round-robin with a guaranteed minimum dwell, so a brief request is still readable by eye.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `HOLD_CYCLES`, 24'd12_000_000: minimum dwell per grant, in clk cycles, ≥1.
- `clk`  in  1: system clock (PLL output).
- `rst_n`  in  1: reset, asynchronous, active-low.
- `default_val`  in  16: value shown when idle.
- `req`  in  NREQ: per-requester display request, level.
- `req_data`  in  16*NREQ: requester i value at bits [16*i+15:16*i].
- `gnt`  out  NREQ: one-hot current owner, all zero when idle.
- `owner`  out  3: index of current owner, 0 when idle.
- `busy`  out  1: display owned by a requester.
- `done`  out  1: one-cycle pulse when a grant ends.
- `disp_val`  out  16: value to the seg4x7 `in` port.

## Operation
- States:
  - IDLE: no owner.
  - HOLD: owner granted, dwell counter running.
  - EXTEND: dwell met, owner still requesting.
- Round-robin priority: search starts at index (last_owner+1) mod NREQ; last_owner resets to NREQ-1, so index 0 wins first after reset.
- IDLE:
  - disp_val = default_val, registered each cycle.
  - If any req is high: grant the pick, load the dwell counter with HOLD_CYCLES-1, go to HOLD.
- HOLD:
  - While req[owner] is high, disp_val follows req_data[owner] every cycle.
  - When req[owner] is low, disp_val freezes at its last value.
  - The counter decrements each cycle. Other requests are ignored until the counter reaches 0.
- End of dwell (counter = 0), decided in that cycle:
  - Another requester pending: done=1, grant it directly, reload the counter, stay in HOLD. There is no idle gap.
  - Else if req[owner] is high: go to EXTEND.
  - Else: done=1, go to IDLE.
- EXTEND:
  - disp_val keeps following the owner's data.
  - Another req rises: done=1, hand over as above.
  - req[owner] falls: done=1, go to IDLE.
  - If both happen in the same cycle, hand over.
- Handover and first grant update gnt, owner, last_owner and disp_val in the same registered edge. The new disp_val takes the new owner's req_data.
- The owner's own req never causes a re-grant of itself while another requester is pending.

## Timing
- All outputs are registered.
- Reset values:
  - gnt=0, owner=0, busy=0, done=0, disp_val=16'h0000.
  - State IDLE, counter 0, last_owner=NREQ-1.
- Grant latency: req sampled high at edge k gives gnt/busy/disp_val at edge k+1.
- Default latency: default_val change appears on disp_val one cycle later while idle.
- Dwell: gnt for owner i stays high for at least HOLD_CYCLES cycles, counted from the first cycle gnt is high.
- HOLD_CYCLES=1: counter = 0 immediately, so each grant can rotate after one cycle.
- done:
  - Asserted in the cycle whose edge changes the owner or enters IDLE, high for exactly one cycle.
  - It coincides with the first cycle of the new gnt.
- Release to IDLE: gnt/busy clear one edge after the deciding cycle; disp_val shows default_val from that same edge.
- Reset mid-grant: all outputs go immediately to their reset values (asynchronous). The first grant after release goes to the lowest requesting index.
- Counter width: $clog2(HOLD_CYCLES) with a minimum of 1. It never wraps, saturating at 0.

## Structure
- Package `seg7_arb_pkg` holds:
  - the state encoding (IDLE, HOLD, EXTEND);
  - `SEG7_W` = 16;
  - `OWNER_W` = 3.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: req vector and last_owner.
  - Outputs: one-hot and index, plus an `any` flag.
  - It is instantiated once, with the req vector masked to exclude the current owner when handing over.
- The top arbiter holds the FSM, the dwell counter and the output registers.

## Test plan
All scenarios use NREQ=4 and HOLD_CYCLES=8.
- Reset idle: default_val=16'h1234, no req → after reset deasserts, disp_val=16'h1234 next cycle, gnt=0, busy=0.
- Single short request: req[2] high for 1 cycle with data 16'h2222 → gnt=4'b0100 for exactly 8 cycles, disp_val=16'h2222 throughout, done pulse on the cycle gnt clears, then disp_val=default_val.
- Contention: req=4'b1011 held high → gnt sequence 0001, 0010, 1000, 0001, with each grant lasting exactly 8 cycles, a done pulse at each change, and no idle gap.
- Extend and live data: req[1] held high alone with data ramping 1,2,3… → gnt stays 0010 past 8 cycles and disp_val tracks the data with 1-cycle lag. req[3] rising at cycle 20 → handover at edge 21, done=1.
- Dwell protection: req[0] granted, req[3] rises at cycle 2 → gnt stays 0001 until cycle 8, then becomes 1000.
- Async reset mid-HOLD: rst_n low in cycle 4 of a grant to index 2 → gnt=0, disp_val=0 without waiting for a clock edge. After release with req=4'b0110, index 1 is granted first.

Source files
------------

// File: rtl/seg7_disp_arbiter_pkg.sv
// Shared types and widths for the seven-segment display arbiter.
// Holds the FSM state encoding and the dwell-counter width helper.
package seg7_arb_pkg;

  localparam int unsigned SEG7_W  = 16;
  localparam int unsigned OWNER_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_EXTEND = 2'd2
  } arb_state_t;

  // Dwell counter must hold HOLD_CYCLES-1; at least one bit even for HOLD_CYCLES=1.
  function automatic int unsigned cnt_width(input int unsigned hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/seg7_disp_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester found searching upward
// from last_owner+1, wrapping around to index 0.
module rr_pick
  import seg7_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]    i_req,
  input  logic [OWNER_W-1:0] i_last,
  output logic [NREQ-1:0]    o_gnt,
  output logic [OWNER_W-1:0] o_idx,
  output logic               o_any
);

  logic               w_hi_any;
  logic               w_lo_any;
  logic [OWNER_W-1:0] w_hi_idx;
  logic [OWNER_W-1:0] w_lo_idx;

  // Lowest requester above last_owner wins; otherwise the lowest at or below it.
  always_comb begin
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (i_req[j]) begin
        if (j > 32'(i_last)) begin
          if (!w_hi_any) begin
            w_hi_any = 1'b1;
            w_hi_idx = OWNER_W'(j);
          end
        end else if (!w_lo_any) begin
          w_lo_any = 1'b1;
          w_lo_idx = OWNER_W'(j);
        end
      end
    end
  end

  always_comb begin
    o_any = w_hi_any | w_lo_any;
    o_idx = w_hi_any ? w_hi_idx : w_lo_idx;
    o_gnt = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      o_gnt[j] = o_any && (32'(o_idx) == j);
    end
  end

endmodule

// File: rtl/seg7_disp_arbiter.sv
// Round-robin owner of the shared 4-digit display with a minimum dwell per
// grant; drives the scanner's value bus, falling back to default_val when idle.
module seg7_disp_arbiter
  import seg7_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter logic [23:0] HOLD_CYCLES = 24'd12_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEG7_W-1:0]        default_val,
  input  logic [NREQ-1:0]          req,
  input  logic [SEG7_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [OWNER_W-1:0]       owner,
  output logic                     busy,
  output logic                     done,
  output logic [SEG7_W-1:0]        disp_val
);

  localparam int unsigned   CW   = cnt_width(32'(HOLD_CYCLES));
  localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 24'd1);

  arb_state_t         r_state;
  logic [CW-1:0]      r_cnt;
  logic [OWNER_W-1:0] r_last;

  logic [NREQ-1:0]    w_mask_req;
  logic [NREQ-1:0]    w_pick_gnt;
  logic [OWNER_W-1:0] w_pick_idx;
  logic               w_pick_any;
  logic [SEG7_W-1:0]  w_own_data;
  logic [SEG7_W-1:0]  w_pick_data;
  logic               w_own_req;
  logic               w_grant;
  logic               w_release;

  // The current owner is masked so it can never re-win while others wait.
  assign w_mask_req = req & ~gnt;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req  (w_mask_req),
    .i_last (r_last),
    .o_gnt  (w_pick_gnt),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  always_comb begin
    w_own_data  = '0;
    w_pick_data = '0;
    w_own_req   = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (gnt[j]) begin
        w_own_data = req_data[SEG7_W*j +: SEG7_W];
        w_own_req  = req[j];
      end
      if (w_pick_gnt[j]) begin
        w_pick_data = req_data[SEG7_W*j +: SEG7_W];
      end
    end
  end

  // Grant/release decisions; a pending handover beats the owner dropping out.
  always_comb begin
    w_grant   = 1'b0;
    w_release = 1'b0;
    unique case (r_state)
      ST_IDLE: w_grant = w_pick_any;
      ST_HOLD: begin
        if (r_cnt == '0) begin
          if (w_pick_any)      w_grant   = 1'b1;
          else if (!w_own_req) w_release = 1'b1;
        end
      end
      ST_EXTEND: begin
        if (w_pick_any)      w_grant   = 1'b1;
        else if (!w_own_req) w_release = 1'b1;
      end
      default: w_release = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_last   <= OWNER_W'(NREQ - 1);
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      disp_val <= '0;
    end else begin
      done <= w_release | (w_grant & (r_state != ST_IDLE));
      if (w_grant) begin
        r_state  <= ST_HOLD;
        r_cnt    <= LOAD;
        r_last   <= w_pick_idx;
        gnt      <= w_pick_gnt;
        owner    <= w_pick_idx;
        busy     <= 1'b1;
        disp_val <= w_pick_data;
      end else if (w_release) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        gnt      <= '0;
        owner    <= '0;
        busy     <= 1'b0;
        disp_val <= default_val;
      end else begin
        unique case (r_state)
          ST_IDLE: disp_val <= default_val;
          ST_HOLD: begin
            if (r_cnt != '0) r_cnt   <= r_cnt - CW'(1);
            else             r_state <= ST_EXTEND;
            if (w_own_req)   disp_val <= w_own_data;
          end
          ST_EXTEND: disp_val <= w_own_data;
          default:   r_state  <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
